// File: rtl/rv_hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: shadows EX/MEM destination info,
// registers EX operand forward selects, and drives load-use stall and branch-squash controls.
module rv_hazard_forward_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      ex_branch_taken,
    input  logic                      mem_stall,
    output logic [1:0]                forward_ex_rs1,
    output logic [1:0]                forward_ex_rs2,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_id,
    output logic                      flush_ex,
    output logic [CNT_WIDTH-1:0]      perf_bubble_cnt
);

    // WB-stage producers are covered by register-file write-through, so only the
    // EX and MEM shadows feed any decision; MEM's load flag is never consulted.
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q, mem_rd_q;
    logic                      ex_valid_q, ex_reg_write_q, ex_mem_read_q;
    logic                      mem_valid_q, mem_reg_write_q;
    logic [1:0]                fwd_rs1_q, fwd_rs2_q, fwd_rs1_d, fwd_rs2_d;
    logic [CNT_WIDTH-1:0]      bubble_cnt_q;

    logic ex_writes, mem_writes, load_use;
    logic hold, squash, bubble;

    function automatic logic [1:0] fwd_sel(
        input logic                      used,
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic                      ex_w,
        input logic [REG_ADDR_WIDTH-1:0] ex_rd,
        input logic                      mem_w,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && ex_w && addr == ex_rd) begin
            sel = 2'b11;
        end else if (used && mem_w && addr == mem_rd) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        ex_writes  = ex_valid_q & ex_reg_write_q & (ex_rd_q != '0);
        mem_writes = mem_valid_q & mem_reg_write_q & (mem_rd_q != '0);
        load_use   = id_valid & ex_writes & ex_mem_read_q &
                     ((id_rs1_used & (id_rs1_addr == ex_rd_q)) |
                      (id_rs2_used & (id_rs2_addr == ex_rd_q)));
        hold       = mem_stall;
        squash     = ~mem_stall & ex_branch_taken;
        bubble     = ~mem_stall & (ex_branch_taken | load_use);
        fwd_rs1_d  = fwd_sel(id_rs1_used, id_rs1_addr, ex_writes, ex_rd_q, mem_writes, mem_rd_q);
        fwd_rs2_d  = fwd_sel(id_rs2_used, id_rs2_addr, ex_writes, ex_rd_q, mem_writes, mem_rd_q);
    end

    always_comb begin
        stall_if = ~rst & (hold | (~ex_branch_taken & load_use));
        stall_id = stall_if;
        flush_id = ~rst & squash;
        flush_ex = ~rst & bubble;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd_q         <= '0;
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_rd_q        <= '0;
            mem_valid_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            fwd_rs1_q       <= 2'b00;
            fwd_rs2_q       <= 2'b00;
            bubble_cnt_q    <= '0;
        end else if (!hold) begin
            mem_rd_q        <= ex_rd_q;
            mem_valid_q     <= ex_valid_q;
            mem_reg_write_q <= ex_reg_write_q;
            if (bubble) begin
                ex_rd_q        <= '0;
                ex_valid_q     <= 1'b0;
                ex_reg_write_q <= 1'b0;
                ex_mem_read_q  <= 1'b0;
                fwd_rs1_q      <= 2'b00;
                fwd_rs2_q      <= 2'b00;
                if (!(&bubble_cnt_q)) begin
                    bubble_cnt_q <= bubble_cnt_q + 1'b1;
                end
            end else begin
                ex_rd_q        <= id_rd_addr;
                ex_valid_q     <= id_valid;
                ex_reg_write_q <= id_reg_write;
                ex_mem_read_q  <= id_mem_read;
                fwd_rs1_q      <= fwd_rs1_d;
                fwd_rs2_q      <= fwd_rs2_d;
            end
        end
    end

    assign forward_ex_rs1  = fwd_rs1_q;
    assign forward_ex_rs2  = fwd_rs2_q;
    assign perf_bubble_cnt = bubble_cnt_q;

endmodule
